mbox_dispatch: RTL
==================

Name: mbox_dispatch

Overview:
- Downstream consumer of the mailbox write-FIFO stream, sitting after the FIFO fed by the mailbox write controller.
- Pops entries of the form {dest_cpu, addr, data}, decodes the destination CPU and deposits addr/data into that CPU's one-deep receive slot.
- Raises a per-CPU interrupt while the slot is occupied, and serves a per-CPU read handshake that drains the slot.
- Reports entries addressed to a nonexistent CPU, and entries stalled too long behind a full slot.

Parameters:
- W_WIDTH_SYS, 32: data word width.
- WIDTH_ADDR, 32: address field width.
- FIFO_DATA, 32+WIDTH_ADDR+W_WIDTH_SYS: stream entry width. Must equal 32+WIDTH_ADDR+W_WIDTH_SYS.
- N_NUMB_CPU, 4: number of destination CPUs/slots.
- STALL_MAX, 255: WAIT cycles before err_stall_o asserts. 16-bit counter.

Ports:
- clk, in, 1: system clock. Only clock.
- rst, in, 1: synchronous, active-high reset.
- m_tdata_i, in, FIFO_DATA: entry. [FIFO_DATA-1 -: 32]=dest_cpu, next WIDTH_ADDR bits=addr, [W_WIDTH_SYS-1:0]=data.
- m_tvalid_i, in, 1: entry valid.
- m_tready_o, out, 1: block accepts entry.
- rd_req_i, in, N_NUMB_CPU: per-CPU read request (level).
- rd_ack_o, out, N_NUMB_CPU: per-CPU one-cycle read acknowledge.
- rd_addr_o, out, N_NUMB_CPU*WIDTH_ADDR: per-CPU slot addr. CPU k at [k*WIDTH_ADDR +: WIDTH_ADDR].
- rd_data_o, out, N_NUMB_CPU*W_WIDTH_SYS: per-CPU slot data, packed the same way.
- irq_o, out, N_NUMB_CPU: slot k occupied.
- err_bad_cpu_o, out, 1: one-cycle pulse when an entry with dest_cpu >= N_NUMB_CPU is dropped.
- err_stall_o, out, 1: stall-timeout flag (level).

Behaviour:
- Reset (rst=1 at a clk edge) clears every output, all slots, valid bits, the hold register and the stall counter, and sets state=IDLE.
  - Reset mid-operation discards the entry in the hold register.
  - m_tready_o=0 during reset.
- All outputs are registered. m_tready_o is 1 exactly while state==IDLE.
- FSM states: IDLE, CHK, WAIT.
  - IDLE: on m_tvalid_i && m_tready_o, latch m_tdata_i into the hold register and go to CHK.
  - CHK, dest >= N_NUMB_CPU: pulse err_bad_cpu_o for the next cycle, drop the entry, go to IDLE.
  - CHK, slot[dest] empty: write addr/data, set valid[dest], go to IDLE.
  - CHK, slot[dest] full: go to WAIT with stall counter=0.
  - WAIT: increment the stall counter each cycle, saturating.
    - When the counter reaches STALL_MAX, set err_stall_o.
    - When valid[dest]==0, write the slot, set valid, clear err_stall_o and the counter, go to IDLE.
- Throughput: one entry per 2 cycles (IDLE→CHK→IDLE).
- Head-of-line blocking is intended: a full slot stalls every later entry.
- The emptiness check uses the registered valid bit. A slot cleared by a read in the same cycle as CHK counts as full, and the entry is written one cycle later via WAIT. Write and clear never hit the same slot in one cycle.
- Read, per CPU k: pop when rd_req_i[k] && valid[k] && !rd_ack_o[k]. At that edge:
  - rd_ack_o[k]<=1 for exactly one cycle.
  - rd_addr_o/rd_data_o slice k <= slot contents (held until the next pop).
  - valid[k]<=0.
- A held rd_req_i pops at most once per 2 cycles. A request against an empty slot waits with no ack.
- irq_o[k] = valid[k], registered. It rises the cycle after the slot write and falls the cycle after the pop.
- Reads on different CPUs are independent and concurrent.
- dest_cpu uses the full 32-bit compare against N_NUMB_CPU. There is no truncation/aliasing.
- m_tvalid_i may drop without consequence while m_tready_o=0. Data is sampled only on the accepting edge.

Test Plan:
1. Reset, then push {dest=2, addr=0x10, data=0xCAFE} → m_tready_o low 1 cycle. irq_o=4'b0100 two cycles after accept. rd_req_i[2]=1 → rd_ack_o[2] pulse, rd_addr slice2=0x10, rd_data slice2=0xCAFE, irq_o[2]=0 next cycle.
2. Push dest=7 with N_NUMB_CPU=4 → err_bad_cpu_o single-cycle pulse. No irq. Block back in IDLE, accepting next entry 2 cycles after accept.
3. Two entries to dest=1 with no read → second enters WAIT, m_tready_o=0. After 255 stall cycles err_stall_o=1. Read CPU1 → ack data1. Next cycle entry2 written, err_stall_o=0. Second read returns data2.
4. Simultaneous: entry to dest=0 reaches CHK in the same cycle CPU0 pops a full slot → ack returns old data, new entry written one cycle later, irq_o[0] stays 1 in the steady state.
5. Back-to-back entries to dest 0,1,2,3 with rd_req_i=4'hF held → each CPU gets exactly one ack per entry, no duplicate pops. Accept spacing is 2 cycles.
6. Assert rst while in WAIT → all outputs 0, m_tready_o=1 the cycle after rst drops, held entry lost.

Source files
------------

// File: rtl/mbox_dispatch.sv
// Mailbox dispatcher: pops {dest_cpu, addr, data} entries and deposits them into
// per-CPU one-deep receive slots, with interrupt, read handshake and error reporting.
module mbox_dispatch #(
  parameter int unsigned W_WIDTH_SYS = 32,
  parameter int unsigned WIDTH_ADDR  = 32,
  parameter int unsigned FIFO_DATA   = 32 + WIDTH_ADDR + W_WIDTH_SYS,
  parameter int unsigned N_NUMB_CPU  = 4,
  parameter int unsigned STALL_MAX   = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FIFO_DATA-1:0]              m_tdata_i,
  input  logic                              m_tvalid_i,
  output logic                              m_tready_o,
  input  logic [N_NUMB_CPU-1:0]             rd_req_i,
  output logic [N_NUMB_CPU-1:0]             rd_ack_o,
  output logic [N_NUMB_CPU*WIDTH_ADDR-1:0]  rd_addr_o,
  output logic [N_NUMB_CPU*W_WIDTH_SYS-1:0] rd_data_o,
  output logic [N_NUMB_CPU-1:0]             irq_o,
  output logic                              err_bad_cpu_o,
  output logic                              err_stall_o
);

  localparam int unsigned IDX_W = (N_NUMB_CPU > 1) ? $clog2(N_NUMB_CPU) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_CHK, S_WAIT} state_e;

  state_e                              state_q, state_d;
  logic [FIFO_DATA-1:0]                hold_q, hold_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [N_NUMB_CPU-1:0]               valid_q, valid_d;
  logic [WIDTH_ADDR-1:0]               slot_addr_q [N_NUMB_CPU];
  logic [WIDTH_ADDR-1:0]               slot_addr_d [N_NUMB_CPU];
  logic [W_WIDTH_SYS-1:0]              slot_data_q [N_NUMB_CPU];
  logic [W_WIDTH_SYS-1:0]              slot_data_d [N_NUMB_CPU];
  logic                                ready_q, ready_d;
  logic [N_NUMB_CPU-1:0]               ack_q, ack_d;
  logic [N_NUMB_CPU*WIDTH_ADDR-1:0]    rd_addr_q, rd_addr_d;
  logic [N_NUMB_CPU*W_WIDTH_SYS-1:0]   rd_data_q, rd_data_d;
  logic [N_NUMB_CPU-1:0]               irq_q, irq_d;
  logic                                bad_q, bad_d;
  logic                                stall_q, stall_d;

  logic [31:0]                         hold_dest;
  logic [WIDTH_ADDR-1:0]               hold_addr;
  logic [W_WIDTH_SYS-1:0]              hold_data;
  logic [IDX_W-1:0]                    dest_idx;
  logic                                dest_bad;
  logic                                slot_write;

  assign hold_dest = hold_q[FIFO_DATA-1 -: 32];
  assign hold_addr = hold_q[W_WIDTH_SYS +: WIDTH_ADDR];
  assign hold_data = hold_q[W_WIDTH_SYS-1:0];
  assign dest_idx  = hold_dest[IDX_W-1:0];
  assign dest_bad  = (hold_dest >= 32'(N_NUMB_CPU));

  // Next-state: read pops, dispatch FSM, slot write-back
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    ack_d       = '0;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    bad_d       = 1'b0;
    stall_d     = stall_q;
    slot_write  = 1'b0;

    for (int unsigned k = 0; k < N_NUMB_CPU; k++) begin
      if (rd_req_i[k] && valid_q[k] && !ack_q[k]) begin
        ack_d[k]                                 = 1'b1;
        rd_addr_d[k*WIDTH_ADDR +: WIDTH_ADDR]    = slot_addr_q[k];
        rd_data_d[k*W_WIDTH_SYS +: W_WIDTH_SYS]  = slot_data_q[k];
        valid_d[k]                               = 1'b0;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (m_tvalid_i && ready_q) begin
          hold_d  = m_tdata_i;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (dest_bad) begin
          bad_d   = 1'b1;
          state_d = S_IDLE;
        end else if (!valid_q[dest_idx]) begin
          slot_write = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!valid_q[dest_idx]) begin
          slot_write = 1'b1;
          stall_d    = 1'b0;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d >= CNT_W'(STALL_MAX)) stall_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A write only targets an empty slot, so it never collides with a pop
    if (slot_write) begin
      slot_addr_d[dest_idx] = hold_addr;
      slot_data_d[dest_idx] = hold_data;
      valid_d[dest_idx]     = 1'b1;
    end

    ready_d = (state_d == S_IDLE);
    irq_d   = valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= '0;
      ready_q   <= 1'b0;
      ack_q     <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      irq_q     <= '0;
      bad_q     <= 1'b0;
      stall_q   <= 1'b0;
      for (int unsigned k = 0; k < N_NUMB_CPU; k++) begin
        slot_addr_q[k] <= '0;
        slot_data_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      ack_q       <= ack_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      irq_q       <= irq_d;
      bad_q       <= bad_d;
      stall_q     <= stall_d;
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
    end
  end

  assign m_tready_o    = ready_q;
  assign rd_ack_o      = ack_q;
  assign rd_addr_o     = rd_addr_q;
  assign rd_data_o     = rd_data_q;
  assign irq_o         = irq_q;
  assign err_bad_cpu_o = bad_q;
  assign err_stall_o   = stall_q;

endmodule
